axi_burst_rw_master: RTL and testbench

//  AXI4 burst master driven by a simple user command port. One INCR burst per

---
 rtl/axi_burst_rw_master_if.sv | 62 ++++++
 rtl/axi_burst_rw_master.sv | 212 +++++++++++++++++++++
 tb/tb_axi_burst_rw_master.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_rw_master_if.sv
// AXI4 write/read channel bundle between the burst master and a memory slave.
// Master drives addresses, write data and response readies; slave the rest.
interface axi_burst_rw_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_rw_master.sv
// AXI4 INCR burst master: one write or read burst per user_start edge.
// Write beats fetched through a stall handshake, read beats strobed out.
module axi_burst_rw_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BLEN_W = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  user_start,
  input  logic                  user_w_r,
  input  logic [ADDR_W-1:0]     user_addr_in,
  input  logic [BLEN_W-1:0]     user_burst_len_in,
  input  logic [DATA_W/8-1:0]   user_data_strb,
  input  logic [DATA_W-1:0]     user_data_in,
  output logic [DATA_W-1:0]     user_data_out,
  output logic                  user_data_out_en,
  output logic                  user_stall_data,
  output logic                  user_free,
  output logic [1:0]            user_status,
  axi_burst_rw_master_if.master m_axi
);
  localparam int         SB   = DATA_W / 8;
  localparam logic [2:0] SIZE = 3'($clog2(SB));
  localparam logic [1:0] INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_WDAT,
    S_WFETCH,
    S_B,
    S_AR,
    S_R
  } state_t;

  state_t state, state_n;

  logic              start_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BLEN_W-1:0] len_q;
  logic [SB-1:0]     strb_q;
  logic [DATA_W-1:0] wbuf;
  logic [BLEN_W-1:0] beat;
  logic              fcnt;
  logic              rgap;

  logic start_edge;
  logic last_beat;
  logic launch;
  logic w_fire;
  logic b_fire;
  logic r_fire;

  logic aw_v;
  logic w_v;
  logic b_r;
  logic ar_v;
  logic r_r;
  logic stall;
  logic free;

  assign start_edge = user_start & ~start_q;
  assign last_beat  = (beat == len_q);
  assign launch     = (state == S_IDLE) & start_edge;
  assign w_fire     = w_v & m_axi.wready;
  assign b_fire     = b_r & m_axi.bvalid;
  assign r_fire     = r_r & m_axi.rvalid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    aw_v    = 1'b0;
    w_v     = 1'b0;
    b_r     = 1'b0;
    ar_v    = 1'b0;
    r_r     = 1'b0;
    stall   = 1'b1;
    free    = 1'b0;
    unique case (state)
      S_IDLE: begin
        free = 1'b1;
        if (start_edge) begin
          state_n = user_w_r ? S_AR : S_AW;
        end
      end
      S_AW: begin
        aw_v = 1'b1;
        if (m_axi.awready) begin
          state_n = S_WDAT;
        end
      end
      S_WDAT: begin
        w_v = 1'b1;
        if (m_axi.wready) begin
          if (last_beat) begin
            state_n = S_B;
          end else if (strb_q != '0) begin
            state_n = S_WFETCH;
          end
        end
      end
      S_WFETCH: begin
        stall = 1'b0;
        if (fcnt) begin
          state_n = S_WDAT;
        end
      end
      S_B: begin
        b_r = 1'b1;
        if (m_axi.bvalid) begin
          state_n = S_IDLE;
        end
      end
      S_AR: begin
        ar_v = 1'b1;
        if (m_axi.arready) begin
          state_n = S_R;
        end
      end
      S_R: begin
        stall = 1'b0;
        r_r   = ~rgap;
        if (r_r && m_axi.rvalid && (m_axi.rlast || last_beat)) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      start_q          <= 1'b1;
      addr_q           <= '0;
      len_q            <= '0;
      strb_q           <= '0;
      wbuf             <= '0;
      beat             <= '0;
      fcnt             <= 1'b0;
      rgap             <= 1'b0;
      user_data_out    <= '0;
      user_data_out_en <= 1'b0;
      user_status      <= 2'b00;
    end else begin
      start_q          <= user_start;
      rgap             <= r_fire;
      user_data_out_en <= 1'b0;
      if (launch) begin
        addr_q <= user_addr_in;
        len_q  <= user_burst_len_in;
        strb_q <= user_data_strb;
        wbuf   <= user_data_in;
        beat   <= '0;
        fcnt   <= 1'b0;
      end
      if (w_fire && !last_beat) begin
        beat <= beat + 1'b1;
      end
      // User data is sampled on the second edge of the fetch window
      if (state == S_WFETCH) begin
        fcnt <= ~fcnt;
        if (fcnt) begin
          wbuf <= user_data_in;
        end
      end
      if (b_fire) begin
        user_status <= m_axi.bresp;
      end
      if (r_fire) begin
        user_data_out    <= m_axi.rdata;
        user_data_out_en <= 1'b1;
        beat             <= beat + 1'b1;
        // First beat restarts the worst-response tracking
        if (beat == '0 || m_axi.rresp > user_status) begin
          user_status <= m_axi.rresp;
        end
      end
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(len_q);
  assign m_axi.awsize  = SIZE;
  assign m_axi.awburst = INCR;
  assign m_axi.awvalid = aw_v;

  assign m_axi.wdata   = wbuf;
  assign m_axi.wstrb   = strb_q;
  assign m_axi.wlast   = w_v & last_beat;
  assign m_axi.wvalid  = w_v;

  assign m_axi.bready  = b_r;

  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'(len_q);
  assign m_axi.arsize  = SIZE;
  assign m_axi.arburst = INCR;
  assign m_axi.arvalid = ar_v;

  assign m_axi.rready  = r_r;

  assign user_stall_data = stall;
  assign user_free       = free & ~areset;
endmodule

// File: tb/tb_axi_burst_rw_master.sv
// Bench for axi_burst_rw_master: random-ready AXI slave with byte memory,
// user-side data supplier and a reference memory built from the commands.
module tb_axi_burst_rw_master;
  logic        aclk = 1'b0;
  logic        areset;
  logic        user_start;
  logic        user_w_r;
  logic [31:0] user_addr_in;
  logic [3:0]  user_burst_len_in;
  logic [7:0]  user_data_strb;
  logic [63:0] user_data_in;
  logic [63:0] user_data_out;
  logic        user_data_out_en;
  logic        user_stall_data;
  logic        user_free;
  logic [1:0]  user_status;

  axi_burst_rw_master_if #(.ADDR_W(32), .DATA_W(64)) m_axi ();

  axi_burst_rw_master #(.ADDR_W(32), .DATA_W(64), .BLEN_W(4)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .user_start        (user_start),
    .user_w_r          (user_w_r),
    .user_addr_in      (user_addr_in),
    .user_burst_len_in (user_burst_len_in),
    .user_data_strb    (user_data_strb),
    .user_data_in      (user_data_in),
    .user_data_out     (user_data_out),
    .user_data_out_en  (user_data_out_en),
    .user_stall_data   (user_stall_data),
    .user_free         (user_free),
    .user_status       (user_status),
    .m_axi             (m_axi)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int fails  = 0;
  longint cyc = 0;
  longint last_en = 0;
  bit have_en = 1'b0;
  int aw_cnt = 0;
  int ar_cnt = 0;
  int cmd_n  = 0;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst;
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  bit          wl_q[$];
  logic [63:0] rd_q[$];
  logic [63:0] smem [logic [31:0]];
  logic [63:0] rmem [logic [31:0]];
  logic [31:0] w_ptr;
  bit b_pend = 1'b0;
  bit b_fire = 1'b0;
  bit r_act  = 1'b0;
  bit r_fire = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg [16];
  int r_idx = 0;
  int r_len = 0;
  logic [31:0] r_addr;
  logic [63:0] wlist [16];
  int widx = 0;
  int fetches = 0;
  bit wr_act = 1'b0;
  bit prev_stall = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] s_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : 64'd0;
  endfunction

  function automatic logic [63:0] r_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 64'd0;
  endfunction

  // Slave, read-strobe monitor and user write-data supplier
  initial begin
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    m_axi.arready = 1'b0;
    m_axi.rvalid  = 1'b0;
    m_axi.rdata   = 64'd0;
    m_axi.rresp   = 2'b00;
    m_axi.rlast   = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        m_axi.bvalid  = 1'b0;
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b0;
        m_axi.rlast   = 1'b0;
        b_pend = 1'b0;
        b_fire = 1'b0;
        r_act  = 1'b0;
        r_fire = 1'b0;
        prev_stall = 1'b1;
      end else begin
        if (b_fire) begin
          m_axi.bvalid = 1'b0;
          b_pend = 1'b0;
        end
        if (b_pend && !m_axi.bvalid && $urandom_range(0, 1) == 1) begin
          m_axi.bvalid = 1'b1;
          m_axi.bresp  = bresp_cfg;
        end
        b_fire = m_axi.bvalid && m_axi.bready;

        if (r_fire) begin
          r_idx++;
          m_axi.rvalid = 1'b0;
          if (r_idx > r_len) r_act = 1'b0;
        end
        if (r_act && !m_axi.rvalid && $urandom_range(0, 2) != 0) begin
          m_axi.rvalid = 1'b1;
          m_axi.rdata  = s_rd(r_addr + 32'(8 * r_idx));
          m_axi.rresp  = rresp_cfg[r_idx];
          m_axi.rlast  = (r_idx == r_len);
        end
        r_fire = m_axi.rvalid && m_axi.rready;

        m_axi.awready = ($urandom_range(0, 3) != 0);
        if (m_axi.awvalid && m_axi.awready) begin
          aw_cnt++;
          aw_addr  = m_axi.awaddr;
          aw_len   = m_axi.awlen;
          aw_size  = m_axi.awsize;
          aw_burst = m_axi.awburst;
          w_ptr    = m_axi.awaddr;
        end

        m_axi.wready = ($urandom_range(0, 2) != 0);
        if (m_axi.wvalid && m_axi.wready) begin
          wd_q.push_back(m_axi.wdata);
          ws_q.push_back(m_axi.wstrb);
          wl_q.push_back(m_axi.wlast);
          smem[w_ptr] = merge(s_rd(w_ptr), m_axi.wdata, m_axi.wstrb);
          w_ptr += 32'd8;
          if (m_axi.wlast) b_pend = 1'b1;
        end

        m_axi.arready = ($urandom_range(0, 3) != 0);
        if (m_axi.arvalid && m_axi.arready) begin
          ar_cnt++;
          ar_addr  = m_axi.araddr;
          ar_len   = m_axi.arlen;
          ar_size  = m_axi.arsize;
          ar_burst = m_axi.arburst;
          r_act    = 1'b1;
          r_idx    = 0;
          r_len    = int'(m_axi.arlen);
          r_addr   = m_axi.araddr;
        end

        if (user_data_out_en) begin
          rd_q.push_back(user_data_out);
          if (have_en) chk("en_gap", 64'((cyc - last_en) >= 2), 64'd1);
          last_en = cyc;
          have_en = 1'b1;
        end

        if (wr_act && prev_stall && !user_stall_data) begin
          widx++;
          fetches++;
          if (widx < 16) user_data_in = wlist[widx];
        end
        prev_stall = user_stall_data;
      end
    end
  end

  task automatic do_cmd(input bit rd, input logic [31:0] addr,
                        input int len, input logic [7:0] strb);
    int n;
    @(negedge aclk);
    wd_q.delete();
    ws_q.delete();
    wl_q.delete();
    rd_q.delete();
    have_en = 1'b0;
    fetches = 0;
    widx = 0;
    user_w_r = rd;
    user_addr_in = addr;
    user_burst_len_in = 4'(len);
    user_data_strb = strb;
    user_data_in = wlist[0];
    wr_act = !rd;
    user_start = 1'b1;
    cmd_n++;
    @(negedge aclk);
    chk("busy", 64'(user_free), 64'd0);
    n = 0;
    while (!user_free && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    chk("done_in_time", 64'(n < 3000), 64'd1);
    repeat (6) @(negedge aclk);
    chk("no_relaunch", 64'(aw_cnt + ar_cnt), 64'(cmd_n));
    chk("free_held", 64'(user_free), 64'd1);
    user_start = 1'b0;
    wr_act = 1'b0;
  endtask

  task automatic check_write(input logic [31:0] addr, input int len,
                             input logic [7:0] strb, input logic [1:0] st);
    logic [63:0] exp;
    chk("aw_addr", 64'(aw_addr), 64'(addr));
    chk("aw_len", 64'(aw_len), 64'(len));
    chk("aw_size", 64'(aw_size), 64'd3);
    chk("aw_burst", 64'(aw_burst), 64'd1);
    chk("w_beats", 64'(wd_q.size()), 64'(len + 1));
    chk("fetches", 64'(fetches), (strb == 8'h00) ? 64'd0 : 64'(len));
    for (int i = 0; i <= len; i++) begin
      exp = (strb == 8'h00) ? wlist[0] : wlist[i];
      if (i < wd_q.size()) begin
        chk("w_data", wd_q[i], exp);
        chk("w_strb", 64'(ws_q[i]), 64'(strb));
        chk("w_last", 64'(wl_q[i]), 64'(i == len));
      end
      rmem[addr + 32'(8 * i)] = merge(r_rd(addr + 32'(8 * i)), exp, strb);
    end
    chk("w_status", 64'(user_status), 64'(st));
  endtask

  task automatic check_read(input logic [31:0] addr, input int len);
    logic [1:0] worst;
    worst = 2'b00;
    chk("ar_addr", 64'(ar_addr), 64'(addr));
    chk("ar_len", 64'(ar_len), 64'(len));
    chk("ar_size", 64'(ar_size), 64'd3);
    chk("ar_burst", 64'(ar_burst), 64'd1);
    chk("r_beats", 64'(rd_q.size()), 64'(len + 1));
    for (int i = 0; i <= len; i++) begin
      if (rresp_cfg[i] > worst) worst = rresp_cfg[i];
      if (i < rd_q.size()) chk("r_data", rd_q[i], r_rd(addr + 32'(8 * i)));
    end
    chk("r_status", 64'(user_status), 64'(worst));
    chk("r_hold", user_data_out, r_rd(addr + 32'(8 * len)));
  endtask

  task automatic fill_wlist();
    for (int i = 0; i < 16; i++) wlist[i] = {$urandom, $urandom};
  endtask

  initial begin
    int n;
    areset = 1'b1;
    user_start = 1'b0;
    user_w_r = 1'b0;
    user_addr_in = 32'd0;
    user_burst_len_in = 4'd0;
    user_data_strb = 8'd0;
    user_data_in = 64'd0;
    for (int i = 0; i < 16; i++) rresp_cfg[i] = 2'b00;
    repeat (3) @(negedge aclk);
    chk("rst_free", 64'(user_free), 64'd0);
    chk("rst_stall", 64'(user_stall_data), 64'd1);
    chk("rst_awvalid", 64'(m_axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi.wvalid), 64'd0);
    chk("rst_arvalid", 64'(m_axi.arvalid), 64'd0);
    chk("rst_bready", 64'(m_axi.bready), 64'd0);
    chk("rst_rready", 64'(m_axi.rready), 64'd0);
    chk("rst_dout", user_data_out, 64'd0);
    chk("rst_dout_en", 64'(user_data_out_en), 64'd0);
    chk("rst_status", 64'(user_status), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_free", 64'(user_free), 64'd1);
    chk("idle_stall", 64'(user_stall_data), 64'd1);

    // single-beat write
    wlist[0] = 64'hF8F4F2F1;
    bresp_cfg = 2'b00;
    do_cmd(1'b0, 32'h1000_0000, 0, 8'hFF);
    check_write(32'h1000_0000, 0, 8'hFF, 2'b00);

    // 16-beat write through the stall handshake
    fill_wlist();
    do_cmd(1'b0, 32'h1000_0080, 15, 8'hFF);
    check_write(32'h1000_0080, 15, 8'hFF, 2'b00);

    do_cmd(1'b1, 32'h1000_0000, 0, 8'h00);
    check_read(32'h1000_0000, 0);
    do_cmd(1'b1, 32'h1000_0080, 15, 8'h00);
    check_read(32'h1000_0080, 15);

    // error response then recovery
    fill_wlist();
    bresp_cfg = 2'b10;
    do_cmd(1'b0, 32'h1000_0100, 3, 8'hFF);
    check_write(32'h1000_0100, 3, 8'hFF, 2'b10);
    fill_wlist();
    bresp_cfg = 2'b00;
    do_cmd(1'b0, 32'h1000_0140, 1, 8'hFF);
    check_write(32'h1000_0140, 1, 8'hFF, 2'b00);

    // zero strobe repeats beat0 without fetching
    fill_wlist();
    do_cmd(1'b0, 32'h1000_0180, 2, 8'h00);
    check_write(32'h1000_0180, 2, 8'h00, 2'b00);

    // partial strobe over earlier data
    fill_wlist();
    do_cmd(1'b0, 32'h1000_0100, 3, 8'h0F);
    check_write(32'h1000_0100, 3, 8'h0F, 2'b00);

    do_cmd(1'b1, 32'h1000_0080, 7, 8'h00);
    check_read(32'h1000_0080, 7);

    rresp_cfg[1] = 2'b10;
    do_cmd(1'b1, 32'h1000_0100, 3, 8'h00);
    check_read(32'h1000_0100, 3);
    rresp_cfg[1] = 2'b00;

    // reset in the middle of a 16-beat write
    fill_wlist();
    @(negedge aclk);
    wd_q.delete();
    ws_q.delete();
    wl_q.delete();
    widx = 0;
    user_w_r = 1'b0;
    user_addr_in = 32'h1000_0200;
    user_burst_len_in = 4'd15;
    user_data_strb = 8'hFF;
    user_data_in = wlist[0];
    wr_act = 1'b1;
    user_start = 1'b1;
    n = 0;
    while (wd_q.size() < 5 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk("reach_beat5", 64'(n < 2000), 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk("abort_awvalid", 64'(m_axi.awvalid), 64'd0);
    chk("abort_wvalid", 64'(m_axi.wvalid), 64'd0);
    chk("abort_arvalid", 64'(m_axi.arvalid), 64'd0);
    chk("abort_bready", 64'(m_axi.bready), 64'd0);
    chk("abort_rready", 64'(m_axi.rready), 64'd0);
    chk("abort_free", 64'(user_free), 64'd0);
    chk("abort_stall", 64'(user_stall_data), 64'd1);
    user_start = 1'b0;
    wr_act = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("after_free", 64'(user_free), 64'd1);
    chk("after_wvalid", 64'(m_axi.wvalid), 64'd0);
    chk("after_status", 64'(user_status), 64'd0);
    chk("after_dout", user_data_out, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
